// File: rtl/maf_driver.sv
// maf_driver: operand transport and timing control around a
// combinational multiply-add unit computing (A x B) + C.
module maf_driver #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_c,
  output logic [31:0]      maf_a,
  output logic [31:0]      maf_b,
  output logic [31:0]      maf_c,
  input  logic [63:0]      maf_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  // Counter preload so the result is sampled LATENCY edges after accept.
  localparam logic [3:0] LoadVal = 4'(LATENCY - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_accept;
  logic       w_deliver;

  // HOLD admits a new triple only on the edge its result leaves.
  assign in_ready  = (r_state == S_IDLE) |
                     ((r_state == S_HOLD) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = (r_state == S_HOLD) & out_ready;
  assign busy      = (r_state != S_IDLE);

  // Control FSM with registered operand, result and count outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      maf_a      <= '0;
      maf_b      <= '0;
      maf_c      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      op_count   <= '0;
    end else begin
      if (w_accept) begin
        maf_a <= in_a;
        maf_b <= in_b;
        maf_c <= in_c;
        r_cnt <= LoadVal;
      end
      if (w_deliver) begin
        op_count <= op_count + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            out_result <= maf_result;
            out_valid  <= 1'b1;
            r_state    <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= in_valid ? S_WAIT : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/maf_driver.md
MAF_DRIVER -- requirements
Module: maf_driver

Interface
REQ-001 Parameter: LATENCY, default 1, number of clk cycles between maf_a/b/c being updated and maf_result being sampled (legal 1..15).
REQ-002 Parameter: CNT_W, default 16, width of op_count.
REQ-003 Reset style SHALL be one clock, with reset asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream operand triple valid.
REQ-007 in_ready  output  1  block can accept a triple.
REQ-008 in_a, in_b, in_c  input  32 each  IEEE-754 single operands, computing (A x B) + C.
REQ-009 maf_a, maf_b, maf_c  output  32 each  operands driven to the combinational MAF unit.
REQ-010 maf_result  input  64  result returned by the MAF unit.
REQ-011 out_valid  output  1  out_result holds a completed result.
REQ-012 out_ready  input  1  downstream accepts out_result.
REQ-013 out_result  output  64  captured MAF result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 op_count  output  CNT_W  number of results accepted downstream.

Function
REQ-016 States SHALL be IDLE, WAIT and HOLD, encoded as registered state.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in HOLD only when out_ready=1, and 0 otherwise.
REQ-018 An accept (in_valid & in_ready) SHALL register in_a/b/c into maf_a/b/c at that edge, load the wait counter with LATENCY-1, and enter WAIT.
REQ-019 maf_a/b/c SHALL hold their last values outside an accept edge and never change during WAIT or HOLD.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when the counter=0, the block SHALL capture maf_result into out_result, set out_valid, and enter HOLD at that edge.
REQ-021 Latency from the accept edge to out_valid rising SHALL be exactly LATENCY cycles.
REQ-022 In HOLD, out_valid=1 and out_result SHALL be stable until out_ready=1.
REQ-023 At the edge where out_valid & out_ready, op_count SHALL increment, and op_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 At the same edge, if in_valid=1 (back-to-back), the block SHALL perform REQ-018 and enter WAIT, with out_valid falling that edge.
REQ-025 At the same edge, if in_valid=0, the block SHALL clear out_valid and go to IDLE.
REQ-026 in_valid and out_ready asserted in WAIT SHALL be ignored, with no accept and no count.
REQ-027 in_valid=1 held while in_ready=0 SHALL NOT be lost, and the block SHALL accept it when in_ready rises.
REQ-028 The block SHALL NOT modify or interpret operand or result bits, acting as a pure transport plus timing controller.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_result=0, maf_a=maf_b=maf_c=0, counter=0, op_count=0, and busy=0, with in_ready=1 combinationally after reset.
REQ-030 Reset asserted in WAIT or HOLD SHALL abandon the in-flight operation with no result delivered and no op_count increment.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Single op, LATENCY=1: (2 x 1) + 3 with A=32'h40000000, B=32'h3F800000, C=32'h40400000; model returns 64'h4014000000000000 -> maf_a/b/c equal the inputs the cycle after accept, out_valid=1 one cycle later with out_result=64'h4014000000000000, and op_count=1 after out_ready.
REQ-033 LATENCY=4: (10 x 5) + 8 -> out_valid rises exactly 4 cycles after the accept edge, and maf_* is stable throughout WAIT.
REQ-034 Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> out_result is stable, in_ready=0, and the second triple is accepted only on the out_ready edge; two results are delivered in order.
REQ-035 Back-to-back stream of 5 triples with out_ready=1 throughout and LATENCY=1 -> one result every 2 cycles, and op_count=5.
REQ-036 Reset mid-WAIT, with rst_n pulsed low during WAIT of (-5 x 2) + 10 -> out_valid=0, all outputs 0, op_count=0, and a fresh (-16 x -8) + 0 completes normally.
REQ-037 Wrap: CNT_W=2, 5 completed results -> op_count=1.
